// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: datapath width, fetch FSM states and the canonical NOP word.
package rv_pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StWait
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_out_buf.sv
// One-entry holding register between the fetch FSM and IF/ID.
module if_out_buf
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_consume,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_4,
  output logic [XLEN-1:0] o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_4;
  logic [XLEN-1:0] r_instr;

  // Flush beats load: a redirect discards a word arriving on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_pc_4  <= '0;
      r_instr <= NOP_INSTR;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_pc_4  <= i_pc + XLEN'(4);
      r_instr <= i_instr;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_pc_4  = r_pc_4;
  assign o_instr = r_valid ? r_instr : NOP_INSTR;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/gnt/rvalid handshake and feeds IF/ID.
module if_fetch_unit
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PC_4_out,
  output logic [XLEN-1:0] instr_out,
  output logic            nop_out,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            r_kill;
  logic            w_kill_next;
  logic [XLEN-1:0] r_fetch_count;

  logic w_buf_valid;
  logic w_req;
  logic w_grant;
  logic w_load;
  logic w_consume;
  logic w_redirect;

  assign w_redirect = redirect_valid && (r_state != StBoot);
  assign w_grant    = w_req && imem_gnt;
  assign w_consume  = w_buf_valid && !stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_kill        <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc   <= w_pc_next;
      r_kill <= w_kill_next;
      if (w_consume && !w_redirect) begin
        r_fetch_count <= r_fetch_count + XLEN'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_kill_next  = r_kill;
    unique case (r_state)
      StBoot: w_state_next = StReq;
      StReq: begin
        if (w_grant) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          w_state_next = StReq;
          w_kill_next  = 1'b0;
          if (!r_kill) begin
            w_pc_next = r_pc + XLEN'(4);
          end
        end
      end
      default: w_state_next = StBoot;
    endcase

    // A request already in flight (or granted now) must have its response swallowed.
    if (w_redirect) begin
      w_pc_next = word_align(redirect_pc);
      if (((r_state == StWait) && !imem_rvalid) || ((r_state == StReq) && w_grant)) begin
        w_kill_next  = 1'b1;
        w_state_next = StWait;
      end else begin
        w_kill_next  = 1'b0;
        w_state_next = StReq;
      end
    end
  end

  always_comb begin
    w_req  = 1'b0;
    w_load = 1'b0;
    unique case (r_state)
      StReq:   w_req = !w_buf_valid || !stall;
      StWait:  w_load = imem_rvalid && !r_kill && !w_redirect;
      default: ;
    endcase
  end

  if_out_buf #(
    .NOP_INSTR(NOP_INSTR)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_consume(w_consume),
    .i_flush  (w_redirect),
    .i_pc     (r_pc),
    .i_instr  (imem_rdata),
    .o_valid  (w_buf_valid),
    .o_pc     (PC_out),
    .o_pc_4   (PC_4_out),
    .o_instr  (instr_out)
  );

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign nop_out     = !w_buf_valid;
  assign fetch_count = r_fetch_count;

endmodule
